// File: rtl/stack_frame_ctrl.sv
// Call-frame push/pop sequencer: validates the request against $sp bounds and alignment,
// streams the words through the data-memory port, then commits the new $sp in one write.
module stack_frame_ctrl #(
  parameter int             N        = 32,
  parameter logic [N-1:0]   SP_TOP   = 32'h0000_03C0,
  parameter logic [N-1:0]   SP_LIMIT = 32'h0000_0300,
  parameter int             CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_push,
  input  logic [CNT_W-1:0] req_count,
  output logic             req_ready,
  input  logic [N-1:0]     sp_value,
  output logic             sp_wr_en,
  output logic [N-1:0]     sp_wr_data,
  output logic [CNT_W-1:0] word_idx,
  input  logic [N-1:0]     push_data,
  output logic             mem_req,
  output logic             mem_we,
  output logic [N-1:0]     mem_addr,
  output logic [N-1:0]     mem_wdata,
  input  logic             mem_ack,
  input  logic [N-1:0]     mem_rdata,
  output logic             pop_valid,
  output logic [N-1:0]     pop_data,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_XFER,
    S_COMMIT,
    S_FIN,
    S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Byte offset of a word count/index, zero-extended to the address width.
  function automatic logic [N-1:0] word_offset(input logic [CNT_W-1:0] cnt);
    word_offset = {{(N-CNT_W-2){1'b0}}, cnt, 2'b00};
  endfunction

  // Bounds are evaluated one bit wider than the address so neither side can wrap.
  function automatic logic push_fits(input logic [N-1:0] sp, input logic [CNT_W-1:0] cnt);
    push_fits = ({1'b0, sp} >= ({1'b0, word_offset(cnt)} + {1'b0, SP_LIMIT}));
  endfunction

  function automatic logic pop_fits(input logic [N-1:0] sp, input logic [CNT_W-1:0] cnt);
    pop_fits = (({1'b0, sp} + {1'b0, word_offset(cnt)}) <= {1'b0, SP_TOP});
  endfunction

  state_t           state, state_nxt;
  logic [CNT_W-1:0] idx, idx_nxt;
  logic             accept;
  logic             rd_ack;

  logic             push_q;
  logic [CNT_W-1:0] count_q;
  logic [N-1:0]     base_q;
  logic [N-1:0]     new_sp_q;

  logic             pop_vld_p1;
  logic [N-1:0]     pop_data_p1;
  logic [CNT_W-1:0] pop_idx_p1;

  assign rd_ack = (state == S_XFER) && mem_ack && !push_q;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          idx_nxt = '0;
          if (req_count == '0)
            state_nxt = S_FIN;
          else if (sp_value[1:0] != 2'b00)
            state_nxt = S_ERR;
          else if (req_push ? !push_fits(sp_value, req_count) : !pop_fits(sp_value, req_count))
            state_nxt = S_ERR;
          else
            state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        if (mem_ack) begin
          if (idx == count_q - CNT_ONE) begin
            state_nxt = S_COMMIT;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + CNT_ONE;
          end
        end
      end
      S_COMMIT: state_nxt = S_FIN;
      S_FIN:    state_nxt = S_IDLE;
      S_ERR:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      pop_vld_p1 <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      pop_vld_p1 <= rd_ack;
    end
  end

  // Request capture: frame base and the final $sp are fixed at accept time.
  always_ff @(posedge clk) begin
    if (accept) begin
      push_q   <= req_push;
      count_q  <= req_count;
      base_q   <= req_push ? (sp_value - word_offset(req_count)) : sp_value;
      new_sp_q <= req_push ? (sp_value - word_offset(req_count))
                           : (sp_value + word_offset(req_count));
    end
  end

  // Stage p1: popped word and its index, presented the cycle after the ack.
  always_ff @(posedge clk) begin
    if (rd_ack) begin
      pop_data_p1 <= mem_rdata;
      pop_idx_p1  <= idx;
    end
  end

  assign req_ready  = (state == S_IDLE);
  assign mem_req    = (state == S_XFER);
  assign mem_we     = (state == S_XFER) && push_q;
  assign mem_addr   = (state == S_XFER) ? (base_q + word_offset(idx)) : '0;
  assign mem_wdata  = ((state == S_XFER) && push_q) ? push_data : '0;
  assign sp_wr_en   = (state == S_COMMIT);
  assign sp_wr_data = (state == S_COMMIT) ? new_sp_q : '0;
  assign done       = (state == S_FIN);
  assign err        = (state == S_ERR);
  assign pop_valid  = pop_vld_p1;
  assign pop_data   = pop_vld_p1 ? pop_data_p1 : '0;
  // Reads do not consume word_idx, so the popped word's index takes priority.
  assign word_idx   = pop_vld_p1 ? pop_idx_p1 :
                      ((state == S_XFER) ? idx : '0);

endmodule

// File: tb/tb_stack_frame_ctrl.sv
// Directed bench for stack_frame_ctrl: vector table of requests with hand-computed
// addresses, $sp results and latencies, plus a reset-during-transfer sequence.
module tb_stack_frame_ctrl;

  localparam logic [31:0] PD_BASE = 32'hA500_0000;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_push;
  logic [3:0]  req_count;
  logic        req_ready;
  logic [31:0] sp_value;
  logic        sp_wr_en;
  logic [31:0] sp_wr_data;
  logic [3:0]  word_idx;
  logic [31:0] push_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        pop_valid;
  logic [31:0] pop_data;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;
  int cur_id = -1;
  logic [31:0] mem_model [0:255];

  stack_frame_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_push   (req_push),
    .req_count  (req_count),
    .req_ready  (req_ready),
    .sp_value   (sp_value),
    .sp_wr_en   (sp_wr_en),
    .sp_wr_data (sp_wr_data),
    .word_idx   (word_idx),
    .push_data  (push_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .pop_valid  (pop_valid),
    .pop_data   (pop_data),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester supplies the word selected by word_idx combinationally.
  always_comb push_data = PD_BASE + {28'b0, word_idx};

  typedef struct {
    logic        push;
    logic [3:0]  count;
    logic [31:0] sp;
    int          ws;
    logic        ok;
    logic [31:0] base;
    logic [31:0] new_sp;
    int          cyc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL vec%0d %s: got %h want %h", cur_id, name, act, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    check({tag, "_memreq"}, {31'b0, mem_req}, 32'd0);
    check({tag, "_spwr"}, {31'b0, sp_wr_en}, 32'd0);
    check({tag, "_done_err"}, {30'b0, done, err}, 32'd0);
    check({tag, "_popv"}, {31'b0, pop_valid}, 32'd0);
    check({tag, "_addr_idx"}, mem_addr | {28'b0, word_idx}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int c, acks, reqs, spw, pops, waitc, done_c, err_c, exp_words, exp_spw;
    logic [31:0] exp_addr;
    logic [31:0] exp_rd[$];
    cur_id = id;
    exp_words = v.ok ? int'(v.count) : 0;
    exp_spw   = (v.ok && v.count != 0) ? 1 : 0;
    sp_value  = v.sp;
    req_push  = v.push;
    req_count = v.count;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    c = 2; acks = 0; reqs = 0; spw = 0; pops = 0; waitc = 0; done_c = 0; err_c = 0;
    check("busy_ready", {31'b0, req_ready}, 32'd0);
    while (done_c == 0 && err_c == 0 && c < 200) begin
      mem_ack = 1'b0;
      if (pop_valid) begin
        if (exp_rd.size() == 0) begin
          check("pop_extra", {31'b0, pop_valid}, 32'd0);
        end else begin
          check("pop_data", pop_data, exp_rd.pop_front());
          check("pop_idx", {28'b0, word_idx}, pops);
        end
        pops++;
      end
      if (mem_req) begin
        reqs++;
        exp_addr = v.base + 32'(4 * acks);
        check("mem_addr", mem_addr, exp_addr);
        check("mem_we", {31'b0, mem_we}, {31'b0, v.push});
        if (v.push) begin
          check("word_idx", {28'b0, word_idx}, acks);
          check("mem_wdata", mem_wdata, PD_BASE + 32'(acks));
        end
        if (waitc < v.ws) begin
          waitc++;
        end else begin
          waitc = 0;
          mem_ack = 1'b1;
          if (v.push) begin
            mem_model[exp_addr[9:2]] = PD_BASE + 32'(acks);
          end else begin
            mem_rdata = mem_model[mem_addr[9:2]];
            exp_rd.push_back(mem_model[exp_addr[9:2]]);
          end
          acks++;
        end
      end
      if (sp_wr_en) begin
        spw++;
        check("sp_wr_data", sp_wr_data, v.new_sp);
      end
      if (done) done_c = c;
      if (err)  err_c = c;
      @(posedge clk); #1;
      c++;
    end
    mem_ack = 1'b0;
    if (v.ok) begin
      check("done_cycle", done_c, v.cyc);
      check("no_err", err_c, 0);
    end else begin
      check("err_cycle", err_c, v.cyc);
      check("no_done", done_c, 0);
    end
    check("words", acks, exp_words);
    check("req_cycles", reqs, exp_words * (v.ws + 1));
    check("sp_writes", spw, exp_spw);
    check("pops", pops, v.push ? 0 : exp_words);
    check("pop_left", exp_rd.size(), 0);
    check("ready_after", {31'b0, req_ready}, 32'd1);
  endtask

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{1'b1, 4'd3,  32'h0000_03C0, 0, 1'b1, 32'h0000_03B4, 32'h0000_03B4, 6};
    vecs[1]  = '{1'b0, 4'd3,  32'h0000_03B4, 0, 1'b1, 32'h0000_03B4, 32'h0000_03C0, 6};
    vecs[2]  = '{1'b1, 4'd1,  32'h0000_0300, 0, 1'b0, 32'h0,         32'h0,         2};
    vecs[3]  = '{1'b0, 4'd1,  32'h0000_03C0, 0, 1'b0, 32'h0,         32'h0,         2};
    vecs[4]  = '{1'b1, 4'd2,  32'h0000_03C0, 3, 1'b1, 32'h0000_03B8, 32'h0000_03B8, 11};
    vecs[5]  = '{1'b0, 4'd2,  32'h0000_03B8, 1, 1'b1, 32'h0000_03B8, 32'h0000_03C0, 7};
    vecs[6]  = '{1'b1, 4'd0,  32'h0000_03C0, 0, 1'b1, 32'h0,         32'h0,         2};
    vecs[7]  = '{1'b1, 4'd1,  32'h0000_03C2, 0, 1'b0, 32'h0,         32'h0,         2};
    vecs[8]  = '{1'b1, 4'd2,  32'h0000_0308, 0, 1'b1, 32'h0000_0300, 32'h0000_0300, 5};
    vecs[9]  = '{1'b1, 4'd3,  32'h0000_0308, 0, 1'b0, 32'h0,         32'h0,         2};
    vecs[10] = '{1'b0, 4'd15, 32'h0000_0384, 0, 1'b1, 32'h0000_0384, 32'h0000_03C0, 18};
    vecs[11] = '{1'b1, 4'd15, 32'h0000_033C, 0, 1'b1, 32'h0000_0300, 32'h0000_0300, 18};
    vecs[12] = '{1'b0, 4'd1,  32'hFFFF_FFFC, 0, 1'b0, 32'h0,         32'h0,         2};
    vecs[13] = '{1'b1, 4'd2,  32'h0000_0004, 0, 1'b0, 32'h0,         32'h0,         2};
    vecs[14] = '{1'b0, 4'd2,  32'h0000_03BC, 0, 1'b0, 32'h0,         32'h0,         2};
    vecs[15] = '{1'b0, 4'd0,  32'h0000_03C2, 0, 1'b1, 32'h0,         32'h0,         2};
    vecs[16] = '{1'b1, 4'd1,  32'h0000_03C0, 0, 1'b1, 32'h0000_03BC, 32'h0000_03BC, 4};

    for (int i = 0; i < 256; i++) mem_model[i] = 32'h5EED_0000 + 32'(i);

    reset = 1'b0; req_valid = 1'b0; req_push = 1'b0; req_count = '0;
    sp_value = 32'h0000_03C0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    reset = 1'b1;
    @(posedge clk); #1;
    check_quiet("idle");

    for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

    // Reset asserted while the second word of a 3-word push is in flight.
    cur_id = 100;
    sp_value = 32'h0000_03C0; req_push = 1'b1; req_count = 4'd3; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_w0_addr", mem_addr, 32'h0000_03B4);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("rst_w1_req", {31'b0, mem_req}, 32'd1);
    check("rst_w1_idx", {28'b0, word_idx}, 32'd1);
    reset = 1'b0;
    #1;
    check_quiet("rst_async");
    @(posedge clk); #1;
    check_quiet("rst_held");
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check_quiet("rst_after");
    end

    run_vec(vecs[16], 101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
